// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: inter-stage pipeline register carrying one packed bundle with
// a valid/ready handshake, stall hold, flush, an optional second (skid) entry,
// and a saturating count of back-pressure cycles for the performance counters.
module pipe_stage_buf #(
  parameter int DATA_W = 71,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   skid_q, skid_d;
  logic                ready_q, ready_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic dnRdy;
  logic validInt;
  logic readyInt;
  logic acceptIn;
  logic moveOut;

  // A stall looks to this stage exactly like a downstream that is not ready.
  assign dnRdy    = ready_i & ~stall_i;
  assign validInt = (state_q != ST_EMPTY);

  // With a skid entry the upstream ready is registered, breaking the timing
  // path from ready_i/stall_i; without one it must be combinational to keep
  // full throughput.
  assign readyInt = SKID ? ready_q : (~validInt | dnRdy);

  assign acceptIn = valid_i & readyInt;
  assign moveOut  = validInt & dnRdy;

  assign ready_o     = readyInt;
  assign valid_o     = validInt;
  assign data_o      = data_q;
  assign occ_o       = state_q;
  assign stall_cnt_o = cnt_q;

  // Next-state, output-register and skid-entry logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (acceptIn) begin
          state_d = ST_FULL;
          data_d  = data_i;
        end
      end
      ST_FULL: begin
        if (acceptIn && moveOut) begin
          data_d = data_i;
        end else if (acceptIn) begin
          if (SKID) begin
            state_d = ST_SKID;
            skid_d  = data_i;
          end
        end else if (moveOut) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (moveOut) begin
          state_d = ST_FULL;
          data_d  = skid_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
      data_d  = data_q;
      skid_d  = skid_q;
    end
    ready_d = (state_d != ST_SKID);
  end

  // Back-pressure counter: counts cycles a valid beat is held, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (validInt && !dnRdy && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and data registers; reset drops every held beat immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: drives three configurations of pipe_stage_buf (skid,
// no-skid, skid with a 4-bit counter) from shared inputs and compares each
// against a small FIFO reference model plus directed expectations.
module tb_pipe_stage_buf;

  localparam int DW = 71;

  logic          clk;
  logic          rst_i;
  logic          valid_i;
  logic [DW-1:0] data_i;
  logic          stall_i;
  logic          flush_i;
  logic          ready_i;

  logic          vOut [3];
  logic          rOut [3];
  logic [DW-1:0] dOut [3];
  logic [1:0]    oOut [3];
  logic [15:0]   cOut [3];
  logic [3:0]    satCnt;

  int checks = 0;
  int errors = 0;

  // Reference model: each instance is a FIFO of capacity 2 (skid) or 1.
  logic [DW-1:0] mEnt  [3][2];
  int            mSize [3];
  logic [DW-1:0] mData [3];
  int            mCnt  [3];
  bit            mSkid [3];
  int            mMax  [3];

  pipe_stage_buf #(.DATA_W(DW), .SKID(1'b1), .CNT_W(16)) u_skid (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rOut[0]),
    .data_i(data_i), .stall_i(stall_i), .flush_i(flush_i), .valid_o(vOut[0]),
    .ready_i(ready_i), .data_o(dOut[0]), .occ_o(oOut[0]), .stall_cnt_o(cOut[0])
  );

  pipe_stage_buf #(.DATA_W(DW), .SKID(1'b0), .CNT_W(16)) u_noskid (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rOut[1]),
    .data_i(data_i), .stall_i(stall_i), .flush_i(flush_i), .valid_o(vOut[1]),
    .ready_i(ready_i), .data_o(dOut[1]), .occ_o(oOut[1]), .stall_cnt_o(cOut[1])
  );

  pipe_stage_buf #(.DATA_W(DW), .SKID(1'b1), .CNT_W(4)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rOut[2]),
    .data_i(data_i), .stall_i(stall_i), .flush_i(flush_i), .valid_o(vOut[2]),
    .ready_i(ready_i), .data_o(dOut[2]), .occ_o(oOut[2]), .stall_cnt_o(satCnt)
  );

  assign cOut[2] = {12'b0, satCnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit modelReady(int k);
    if (mSkid[k]) return (mSize[k] < 2);
    return (mSize[k] == 0) || (ready_i && !stall_i);
  endfunction

  task automatic modelClear();
    for (int k = 0; k < 3; k++) begin
      mSize[k] = 0;
      mData[k] = '0;
      mCnt[k]  = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently applied, then clock the DUTs.
  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      bit dn, vo, rdy, out, acc;
      dn  = ready_i && !stall_i;
      vo  = (mSize[k] > 0);
      rdy = modelReady(k);
      if (vo && !dn && mCnt[k] < mMax[k]) mCnt[k]++;
      if (flush_i) begin
        mSize[k] = 0;
      end else begin
        out = vo && dn;
        acc = valid_i && rdy;
        if (out) begin
          mEnt[k][0] = mEnt[k][1];
          mSize[k]--;
        end
        if (acc) begin
          mEnt[k][mSize[k]] = data_i;
          mSize[k]++;
        end
      end
      if (mSize[k] > 0) mData[k] = mEnt[k][0];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    valid_i = 1'b0;
    data_i  = '0;
    stall_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b1;
  endtask

  task automatic doReset();
    idleInputs();
    rst_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    modelClear();
    rst_i = 1'b1;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_i = 1'b0;
    #1;
    modelClear();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (vOut[k] !== 1'b0 || oOut[k] !== 2'd0 || dOut[k] !== '0 || cOut[k] !== 16'd0) begin
        errors++;
        $display("[TB] FAIL reset_state[%0d] got v=%0b occ=%0d data=%h cnt=%0d want all zero",
                 k, vOut[k], oOut[k], dOut[k], cOut[k]);
      end
    end
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rOut[k] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_ready[%0d] got %0b want 1", k, rOut[k]);
      end
    end
  endtask

  task automatic test_stream();
    doReset();
    ready_i = 1'b1;
    valid_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      data_i = DW'(i);
      tick();
      checks++;
      if (dOut[0] !== DW'(i) || oOut[0] !== 2'd1 || vOut[0] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream_beat%0d got data=%h occ=%0d v=%0b want data=%0h occ=1 v=1",
                 i, dOut[0], oOut[0], vOut[0], i);
      end
    end
    valid_i = 1'b0;
    tick();
    checks++;
    if (oOut[0] !== 2'd0 || vOut[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_drain got occ=%0d v=%0b want occ=0 v=0", oOut[0], vOut[0]);
    end
  endtask

  task automatic test_stall_skid();
    doReset();
    valid_i = 1'b1;
    data_i  = DW'(8'hAA);
    tick();
    stall_i = 1'b1;
    data_i  = DW'(8'hBB);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (dOut[0] !== DW'(8'hAA) || oOut[0] !== 2'd2 || rOut[0] !== 1'b0 || cOut[0] !== 16'd4) begin
      errors++;
      $display("[TB] FAIL stall_hold got data=%h occ=%0d rdy=%0b cnt=%0d want data=aa occ=2 rdy=0 cnt=4",
               dOut[0], oOut[0], rOut[0], cOut[0]);
    end
    valid_i = 1'b0;
    stall_i = 1'b0;
    tick();
    checks++;
    if (dOut[0] !== DW'(8'hBB) || oOut[0] !== 2'd1 || vOut[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_release got data=%h occ=%0d v=%0b want data=bb occ=1 v=1",
               dOut[0], oOut[0], vOut[0]);
    end
    tick();
    checks++;
    if (oOut[0] !== 2'd0 || rOut[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_empty got occ=%0d rdy=%0b want occ=0 rdy=1", oOut[0], rOut[0]);
    end
  endtask

  task automatic test_flush();
    doReset();
    valid_i = 1'b1;
    data_i  = DW'(8'hAA);
    tick();
    stall_i = 1'b1;
    data_i  = DW'(8'hBB);
    tick();
    flush_i = 1'b1;
    data_i  = DW'(8'hCC);
    tick();
    checks++;
    if (vOut[0] !== 1'b0 || oOut[0] !== 2'd0 || rOut[0] !== 1'b1 || dOut[0] !== DW'(8'hAA)) begin
      errors++;
      $display("[TB] FAIL flush_clear got v=%0b occ=%0d rdy=%0b data=%h want v=0 occ=0 rdy=1 data=aa",
               vOut[0], oOut[0], rOut[0], dOut[0]);
    end
    idleInputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (vOut[0] !== 1'b0 || dOut[0] === DW'(8'hCC)) begin
        errors++;
        $display("[TB] FAIL flush_dropped got v=%0b data=%h want v=0 and data not cc", vOut[0], dOut[0]);
      end
    end
  endtask

  task automatic test_saturation();
    doReset();
    valid_i = 1'b1;
    data_i  = DW'(8'h55);
    tick();
    valid_i = 1'b0;
    ready_i = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (cOut[2] !== 16'd15 || cOut[0] !== 16'd20) begin
      errors++;
      $display("[TB] FAIL sat_count got cnt4=%0d cnt16=%0d want 15 and 20", cOut[2], cOut[0]);
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick();
    checks++;
    if (cOut[2] !== 16'd15 || cOut[0] !== 16'd21 || vOut[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_after_flush got cnt4=%0d cnt16=%0d v=%0b want 15, 21, v=0",
               cOut[2], cOut[0], vOut[0]);
    end
  endtask

  task automatic test_noskid_ready();
    doReset();
    valid_i = 1'b1;
    data_i  = DW'(8'h11);
    tick();
    valid_i = 1'b0;
    ready_i = 1'b0;
    #1;
    checks++;
    if (rOut[1] !== 1'b0 || rOut[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL noskid_rdy_low got noskid=%0b skid=%0b want 0 and 1", rOut[1], rOut[0]);
    end
    ready_i = 1'b1;
    #1;
    checks++;
    if (rOut[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL noskid_rdy_high got %0b want 1", rOut[1]);
    end
    stall_i = 1'b1;
    #1;
    checks++;
    if (rOut[1] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL noskid_rdy_stall got %0b want 0", rOut[1]);
    end
    stall_i = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    doReset();
    valid_i = 1'b1;
    data_i  = DW'(8'hAA);
    tick();
    stall_i = 1'b1;
    data_i  = DW'(8'hBB);
    tick();
    tick();
    #2;
    rst_i = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (vOut[k] !== 1'b0 || oOut[k] !== 2'd0 || dOut[k] !== '0 || cOut[k] !== 16'd0) begin
        errors++;
        $display("[TB] FAIL async_reset[%0d] got v=%0b occ=%0d data=%h cnt=%0d want all zero",
                 k, vOut[k], oOut[k], dOut[k], cOut[k]);
      end
    end
    idleInputs();
    @(posedge clk);
    #1;
    modelClear();
    rst_i = 1'b1;
  endtask

  task automatic test_random();
    logic [95:0] r;
    doReset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      r       = {$urandom(), $urandom(), $urandom()};
      data_i  = r[DW-1:0];
      valid_i = ($urandom_range(0, 99) < 70);
      ready_i = ($urandom_range(0, 99) < 75);
      stall_i = ($urandom_range(0, 99) < 15);
      flush_i = ($urandom_range(0, 99) < 5);
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rOut[k] !== modelReady(k)) begin
          errors++;
          $display("[TB] FAIL rand_ready[%0d] cyc%0d got %0b want %0b", k, cyc, rOut[k], modelReady(k));
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (vOut[k] !== (mSize[k] > 0) || oOut[k] !== 2'(mSize[k]) || dOut[k] !== mData[k]
            || cOut[k] !== 16'(mCnt[k])) begin
          errors++;
          $display("[TB] FAIL rand_state[%0d] cyc%0d got v=%0b occ=%0d data=%h cnt=%0d want v=%0b occ=%0d data=%h cnt=%0d",
                   k, cyc, vOut[k], oOut[k], dOut[k], cOut[k], (mSize[k] > 0), mSize[k], mData[k], mCnt[k]);
        end
      end
    end
  endtask

  // Main sequence: directed scenarios first, then randomized traffic against the model.
  initial begin
    mSkid[0] = 1'b1; mMax[0] = 65535;
    mSkid[1] = 1'b0; mMax[1] = 65535;
    mSkid[2] = 1'b1; mMax[2] = 15;
    modelClear();
    idleInputs();
    rst_i = 1'b0;
    test_reset();
    test_stream();
    test_stall_skid();
    test_flush();
    test_saturation();
    test_noskid_ready();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
